grayscale_stream: RTL and testbench
===================================

Name: grayscale_stream

Overview:
- Parametrised successor to the fixed four-pixel grayscale stage of the Sobel edge detector.
- Accepts a buffer of NUM_PIX RGB pixels through a valid/ready handshake and converts them one lane per cycle.
- Supports four run-time-selectable luma modes and holds the result under output backpressure.
- Sits between the pixel-buffer loader and the Sobel kernel stage.

Parameters:
- NUM_PIX, 4: pixels per buffer (≥1).
- CH_W, 8: bits per colour channel; also the gray output width (≥4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input buffer valid
- in_ready  out  1  block can accept a buffer this cycle
- in_pixel_buffer  in  [NUM_PIX-1:0][3*CH_W-1:0]  RGB pixels; per lane R=[3CH_W-1:2CH_W], G=[2CH_W-1:CH_W], B=[CH_W-1:0]
- mode  in  2  luma mode; sampled on accept
- out_valid  out  1  gray_pixel valid
- out_ready  in  1  downstream accepts the result
- gray_pixel  out  [NUM_PIX-1:0][CH_W-1:0]  gray result per lane
- busy  out  1  high in CONV or DONE

Behaviour:
- Reset: rst=1 at a clk edge forces the following, regardless of state (mid-operation work is discarded, no partial output):
  - state=IDLE, lane index=NUM_PIX-1
  - out_valid=0, gray_pixel=0
  - internal capture and result registers=0
- After reset, in_ready=1.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 accepts the buffer: in_pixel_buffer and mode are copied to internal registers, idx=NUM_PIX-1, next state CONV.
  - Upstream may change its inputs after acceptance.
- CONV:
  - Each cycle, lane idx of the captured buffer is converted and written to result lane idx, then idx decrements.
  - Lane NUM_PIX-1 is converted first.
  - After lane 0, next state DONE; gray_pixel is loaded with the full result and out_valid=1 on the same edge.
  - in_ready=0 throughout.
- Latency: accept at edge 0 → out_valid high after edge NUM_PIX.
- DONE:
  - out_valid=1; gray_pixel stays stable until out_ready=1.
  - in_ready equals out_ready.
  - out_ready=1 and in_valid=1 together complete the transfer and accept a new buffer in the same cycle; next state CONV.
  - out_ready=1 alone → next state IDLE.
  - out_valid clears on the transfer edge. gray_pixel keeps its last value until the next result load.
- Throughput: one buffer per NUM_PIX+1 cycles when back-to-back.
- Arithmetic: unsigned, per lane; the final value saturates to 2^CH_W-1 if it exceeds it.
  - mode 0 SHIFT: (R>>2)+(G>>1)+(G>>2)+(B>>4), computed at CH_W+2 bits. This is the legacy weighting; it can overflow and saturates.
  - mode 1 BT601: (77R+150G+29B)>>8, computed at CH_W+8 bits; never saturates.
  - mode 2 AVG: ((R+G+B)*85)>>8, computed at CH_W+9 bits.
  - mode 3 GREEN: G passthrough.
- A mode change while busy has no effect on the buffer in flight.

Optional Feature:
- Macro: GRAYSCALE_SAT_COUNT_EN.
- When defined:
  - Adds output port sat_count, width $clog2(NUM_PIX+1).
  - sat_count is the number of lanes in the current result that saturated.
  - It is loaded together with gray_pixel, held with it, and reset to 0.
- When not defined: the port and its counting logic are absent; all other behaviour is identical.

Decomposition:
- Package gray_pkg:
  - gray_mode_t enum (SHIFT, BT601, AVG, GREEN)
  - gray_state_t enum (IDLE, CONV, DONE)
  - constants C_R=77, C_G=150, C_B=29, C_AVG=85
- Sub-module gray_lane_conv:
  - Combinational; parameter CH_W.
  - Inputs: one RGB pixel and mode.
  - Outputs: gray value and sat flag.
  - One instance is muxed by idx inside grayscale_stream.

Test Plan (NUM_PIX=4, CH_W=8):
- SHIFT: lanes 0x808080, 0xFFFFFF, 0x000000, 0x400000 → gray_pixel lanes 0x88, 0xFF (268 saturated), 0x00, 0x10. out_valid rises 4 cycles after accept. sat_count=1 with GRAYSCALE_SAT_COUNT_EN.
- BT601: lanes 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF → 76, 149, 28, 255.
- AVG and GREEN:
  - AVG 0x306090 → 95.
  - GREEN 0x12AB34 → 0xAB.
  - Changing mode during CONV leaves the result unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid=1, gray_pixel stable, in_ready=0. Then raise out_ready together with in_valid → the transfer and the new accept occur on the same edge, and the next result follows 4 cycles later.
- Reset mid-CONV: assert rst after 2 CONV cycles → next cycle out_valid=0, gray_pixel=0, in_ready=1, busy=0. A subsequent buffer converts correctly.
- Input isolation: change in_pixel_buffer every cycle after accept → the result reflects only the value captured at accept.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared modes, states and luma coefficients for the grayscale stream
package gray_pkg;
  typedef enum logic [1:0] {SHIFT, BT601, AVG, GREEN} gray_mode_t;
  typedef enum logic [1:0] {IDLE, CONV, DONE} gray_state_t;
  localparam int unsigned C_R = 77;
  localparam int unsigned C_G = 150;
  localparam int unsigned C_B = 29;
  localparam int unsigned C_AVG = 85;
endpackage

// File: rtl/gray_lane_conv.sv
// gray_lane_conv: combinational single-pixel luma conversion with saturation flag
module gray_lane_conv import gray_pkg::*; #(
  parameter int CH_W = 8
) (
  input  logic [3*CH_W-1:0] pixel,
  input  gray_mode_t        mode,
  output logic [CH_W-1:0]   gray,
  output logic              sat
);
  localparam int W = CH_W + 9;
  logic [W-1:0] r, g, b, val;
  assign r = W'(pixel[3*CH_W-1:2*CH_W]);
  assign g = W'(pixel[2*CH_W-1:CH_W]);
  assign b = W'(pixel[CH_W-1:0]);
  // one shared width wide enough for every mode keeps all sums exact
  assign val = mode == SHIFT ? (r >> 2) + (g >> 1) + (g >> 2) + (b >> 4) :
               mode == BT601 ? (W'(C_R) * r + W'(C_G) * g + W'(C_B) * b) >> 8 :
               mode == AVG   ? ((r + g + b) * W'(C_AVG)) >> 8 : g;
  assign sat  = |val[W-1:CH_W];
  assign gray = sat ? '1 : val[CH_W-1:0];
endmodule

// File: rtl/grayscale_stream.sv
// grayscale_stream: buffered RGB-to-gray converter, one lane per cycle; GRAYSCALE_SAT_COUNT_EN adds sat_count
module grayscale_stream import gray_pkg::*; #(
  parameter int NUM_PIX = 4,
  parameter int CH_W    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_PIX-1:0][3*CH_W-1:0]   in_pixel_buffer,
  input  logic [1:0]                       mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_PIX-1:0][CH_W-1:0]     gray_pixel,
  output logic                             busy
`ifdef GRAYSCALE_SAT_COUNT_EN
  , output logic [$clog2(NUM_PIX+1)-1:0]   sat_count
`endif
);
  localparam int IW = NUM_PIX > 1 ? $clog2(NUM_PIX) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_PIX - 1);
  gray_state_t state, state_n;
  logic [IW-1:0] idx;
  logic [NUM_PIX-1:0][3*CH_W-1:0] cap;
  gray_mode_t cap_mode;
  logic [NUM_PIX-1:0][CH_W-1:0] res, res_n;
  logic [CH_W-1:0] lane_gray;
  logic accept, last;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = state != IDLE;
  assign last     = idx == '0;
  always_comb begin
    res_n = res;
    res_n[idx] = lane_gray;
  end
  always_comb begin
    state_n = state == IDLE ? (accept ? CONV : IDLE) :
              state == CONV ? (last ? DONE : CONV) :
              out_ready     ? (in_valid ? CONV : IDLE) : DONE;
  end
`ifdef GRAYSCALE_SAT_COUNT_EN
  localparam int SW = $clog2(NUM_PIX + 1);
  logic lane_sat;
  logic [NUM_PIX-1:0] res_sat, res_sat_n;
  logic [SW-1:0] sat_n;
  always_comb begin
    res_sat_n = res_sat;
    res_sat_n[idx] = lane_sat;
    sat_n = '0;
    for (int i = 0; i < NUM_PIX; i++) sat_n = sat_n + SW'(res_sat_n[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sat   <= '0;
      sat_count <= '0;
    end else if (state == CONV) begin
      res_sat <= res_sat_n;
      if (last) sat_count <= sat_n;
    end
  end
  gray_lane_conv #(.CH_W(CH_W)) u_conv (
    .pixel(cap[idx]), .mode(cap_mode), .gray(lane_gray), .sat(lane_sat)
  );
`else
  gray_lane_conv #(.CH_W(CH_W)) u_conv (
    .pixel(cap[idx]), .mode(cap_mode), .gray(lane_gray), .sat()
  );
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= LAST;
      cap        <= '0;
      cap_mode   <= SHIFT;
      res        <= '0;
      gray_pixel <= '0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cap      <= in_pixel_buffer;
        cap_mode <= gray_mode_t'(mode);
        idx      <= LAST;
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
      if (state == CONV) begin
        res <= res_n;
        idx <= last ? LAST : idx - 1'b1;
        if (last) begin
          gray_pixel <= res_n;
          out_valid  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_grayscale_stream.sv
// tb_grayscale_stream: directed checks of conversion modes, latency, backpressure and reset
module tb_grayscale_stream;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [3:0][23:0] in_pixel_buffer = '0;
  logic [1:0] mode = 0;
  logic [3:0][7:0] gray_pixel;
  int total = 0, bad = 0;
`ifdef GRAYSCALE_SAT_COUNT_EN
  logic [2:0] sat_count;
`endif
  always #5 clk = ~clk;
  grayscale_stream #(.NUM_PIX(4), .CH_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel_buffer(in_pixel_buffer), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .gray_pixel(gray_pixel), .busy(busy)
`ifdef GRAYSCALE_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [3:0][23:0] b, input logic [1:0] m, output int lat);
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    in_valid = 1; in_pixel_buffer = b; mode = m;
    tick();
    in_valid = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
  endtask
  task automatic release_out();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (gray_pixel !== 32'h0) begin bad++; $display("FAIL reset_gray got=%h want=0", gray_pixel); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask
  task automatic test_shift();
    int lat;
    run({24'h400000, 24'h000000, 24'hFFFFFF, 24'h808080}, 2'd0, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL shift_latency got=%0d want=4", lat); end
    total++; if (gray_pixel !== {8'h10, 8'h00, 8'hFF, 8'h88}) begin bad++; $display("FAIL shift_gray got=%h want=1000ff88", gray_pixel); end
`ifdef GRAYSCALE_SAT_COUNT_EN
    total++; if (sat_count !== 3'd1) begin bad++; $display("FAIL shift_sat_count got=%0d want=1", sat_count); end
`endif
    release_out();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL shift_release got=v%b r%b b%b want=v0 r1 b0", out_valid, in_ready, busy); end
    total++; if (gray_pixel !== {8'h10, 8'h00, 8'hFF, 8'h88}) begin bad++; $display("FAIL shift_hold_after got=%h want=1000ff88", gray_pixel); end
  endtask
  task automatic test_bt601();
    int lat;
    run({24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000}, 2'd1, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL bt601_latency got=%0d want=4", lat); end
    total++; if (gray_pixel !== {8'd255, 8'd28, 8'd149, 8'd76}) begin bad++; $display("FAIL bt601_gray got=%h want=ff1c954c", gray_pixel); end
`ifdef GRAYSCALE_SAT_COUNT_EN
    total++; if (sat_count !== 3'd0) begin bad++; $display("FAIL bt601_sat_count got=%0d want=0", sat_count); end
`endif
    release_out();
  endtask
  task automatic test_avg_green();
    int lat;
    run({4{24'h306090}}, 2'd2, lat);
    total++; if (gray_pixel !== {4{8'd95}}) begin bad++; $display("FAIL avg_gray got=%h want=5f5f5f5f", gray_pixel); end
    release_out();
    run({4{24'h12AB34}}, 2'd3, lat);
    total++; if (gray_pixel !== {4{8'hAB}}) begin bad++; $display("FAIL green_gray got=%h want=abababab", gray_pixel); end
    release_out();
  endtask
  task automatic test_isolation();
    int lat = -1;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    in_valid = 1; in_pixel_buffer = {4{24'h306090}}; mode = 2'd2;
    tick();
    in_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      mode = 2'(k);
      in_pixel_buffer = {4{24'(k * 24'h131313)}};
      tick();
      if (out_valid) begin lat = k; break; end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL iso_latency got=%0d want=4", lat); end
    total++; if (gray_pixel !== {4{8'd95}}) begin bad++; $display("FAIL iso_gray got=%h want=5f5f5f5f", gray_pixel); end
    release_out();
  endtask
  task automatic test_backpressure();
    int lat;
    logic ok;
    run({4{24'h12AB34}}, 2'd3, lat);
    ok = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || gray_pixel !== {4{8'hAB}}) ok = 0;
    end
    total++; if (!ok) begin bad++; $display("FAIL bp_hold got=v%b r%b g=%h want=v1 r0 g=abababab", out_valid, in_ready, gray_pixel); end
    out_ready = 1; in_valid = 1; mode = 2'd1;
    in_pixel_buffer = {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 0; out_ready = 0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_transfer got=v%b b%b want=v0 b1", out_valid, busy); end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL bp_next_latency got=%0d want=4", lat); end
    total++; if (gray_pixel !== {8'd255, 8'd28, 8'd149, 8'd76}) begin bad++; $display("FAIL bp_next_gray got=%h want=ff1c954c", gray_pixel); end
    release_out();
  endtask
  task automatic test_reset_mid();
    int lat;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    in_valid = 1; in_pixel_buffer = {4{24'h306090}}; mode = 2'd2;
    tick();
    in_valid = 0;
    tick(); tick();
    rst = 1; tick(); rst = 0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ctrl got=v%b b%b r%b want=v0 b0 r1", out_valid, busy, in_ready); end
    total++; if (gray_pixel !== 32'h0) begin bad++; $display("FAIL midrst_gray got=%h want=0", gray_pixel); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_output got=%b want=0", out_valid); end
    run({24'h400000, 24'h000000, 24'hFFFFFF, 24'h808080}, 2'd0, lat);
    total++; if (lat != 4 || gray_pixel !== {8'h10, 8'h00, 8'hFF, 8'h88}) begin bad++; $display("FAIL midrst_after got=lat%0d g=%h want=lat4 g=1000ff88", lat, gray_pixel); end
    release_out();
  endtask
  initial begin
    test_reset();
    test_shift();
    test_bt601();
    test_avg_green();
    test_isolation();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
